// File: rtl/seq_mdu.sv
// seq_mdu: sequential multiply/divide unit.
//   Iterates on operand magnitudes: one shift-add (multiply) or one restoring
//   shift-subtract (divide) step per cycle. Sign fix-up is applied when the
//   result is registered on entry to FIN.
//
//   Optional build macro: MDU_EARLY_OUT_EN
//     When defined, a multiply finishes as soon as the remaining multiplier
//     magnitude bits are all zero (at least one step is always taken).
//     Divide timing is the same in both builds.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous reset, active high
//   start  in   request pulse; accepted in IDLE or FIN, ignored in CALC
//   op     in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a      in   multiplicand / dividend
//   b      in   multiplier / divisor
//   busy   out  operation in progress (CALC)
//   done   out  one-cycle pulse in FIN; hi/lo/dz valid
//   hi     out  product upper half / remainder
//   lo     out  product lower half / quotient
//   dz     out  divide-by-zero flag for the last result
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, one step per cycle
// FIN   | result registered, done pulses; start here chains a new op
module seq_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc;     // product, or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] mcand;   // multiplicand magnitude, shifted left per step
  logic [WIDTH-1:0]   mplier;  // multiplier or divisor magnitude
  logic [CW-1:0]      cnt;     // steps remaining
  logic               is_div;
  logic               neg_q;   // negate product / quotient
  logic               neg_r;   // negate remainder (dividend was negative)
  logic               dz_pend;

  logic             accept;
  logic             fin_now;
  logic             early;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

`ifdef MDU_EARLY_OUT_EN
  // cnt != CNT_INIT guarantees at least one step, so minimum latency is 2.
  assign early = !is_div && (cnt != CNT_INIT) && (mplier == '0);
`else
  assign early = 1'b0;
`endif

  assign accept  = start && (state != CALC);
  assign fin_now = (state == CALC) && (dz_pend || (cnt == '0) || early);

  assign busy = (state == CALC);
  assign done = (state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (fin_now) state_nxt = FIN;
      FIN:     state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Restoring divide step: shift {rem, dividend} left, trial-subtract divisor
  // from the (WIDTH+1)-bit partial remainder.
  logic [WIDTH:0]     div_r;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_nxt;

  always_comb begin
    div_r    = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_r - {1'b0, mplier};
    if (!div_diff[WIDTH])
      div_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_nxt = {div_r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, dvd_fix;

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  // With a zero divisor no step runs, so acc still holds |a|; undoing the
  // magnitude recovers the original dividend.
  assign dvd_fix  = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_pend <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      dz      <= 1'b0;
    end else if (accept) begin
      is_div  <= op[1];
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      dz_pend <= op[1] && (b == '0);
      acc     <= op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
      mcand   <= {{WIDTH{1'b0}}, a_mag};
      mplier  <= b_mag;
      cnt     <= CNT_INIT;
    end else if (fin_now) begin
      if (dz_pend) begin
        hi <= dvd_fix;
        lo <= '1;
        dz <= 1'b1;
      end else if (is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
        dz <= 1'b0;
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
        dz <= 1'b0;
      end
    end else if (state == CALC) begin
      cnt <= cnt - 1'b1;
      if (is_div) begin
        acc <= div_nxt;
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule

// File: tb/tb_seq_mdu.sv
module tb_seq_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  seq_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  function automatic int mul_lat(input logic [W-1:0] m);
    int n = 0;
`ifdef MDU_EARLY_OUT_EN
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    if (n < 1) n = 1;
    return n + 1;
`else
    n = m[0];
    return W + 1 + n - n;
`endif
  endfunction

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [63:0] p;
    longint sx, sy, q, r;
    e.t0 = 0;
    e.dz = 1'b0;
    if (o[1] && y == '0) begin
      e.hi = x; e.lo = '1; e.dz = 1'b1; e.lat = 1;
    end else if (o == 2'b10) begin
      e.lo = x / y; e.hi = x % y; e.lat = W + 1;
    end else if (o == 2'b11) begin
      sx = longint'($signed(x)); sy = longint'($signed(y));
      q = sx / sy; r = sx % sy;
      e.lo = q[W-1:0]; e.hi = r[W-1:0]; e.lat = W + 1;
    end else begin
      if (o == 2'b00) begin
        p = {32'b0, x} * {32'b0, y};
        e.lat = mul_lat(y);
      end else begin
        sx = longint'($signed(x)); sy = longint'($signed(y));
        p = sx * sy;
        e.lat = mul_lat(y[W-1] ? -y : y);
      end
      e.hi = p[63:32]; e.lo = p[31:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        me = sb.pop_front();
        check("hi", hi, me.hi);
        check("lo", lo, me.lo);
        check("dz", dz, me.dz);
        check("latency", cyc - me.t0, me.lat);
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = model(o, x, y);
    e.t0 = cyc;
    sb.push_back(e);
    check("busy_after_start", busy, 1);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    launch(o, x, y);
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((sb.size() != 0 || busy) && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) check("timeout", 0, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   ro;
    int           k;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dz", dz, 0);
    rst = 1'b0;

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    do_op(2'b01, -32'sd3, 32'd5);               wait_idle();
    do_op(2'b11, -32'sd7, 32'd2);               wait_idle();
    do_op(2'b10, 32'h1234_5678, 32'd0);         wait_idle();
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    do_op(2'b11, -32'sd9, 32'd0);               wait_idle();

    // Second start while CALC runs must be ignored.
    do_op(2'b00, 32'h0001_0003, 32'h8000_0011);
    repeat (9) @(negedge clk);
    op = 2'b10; a = 32'd55; b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start held high in FIN chains a new op back-to-back.
    do_op(2'b00, 32'd1234, 32'h8765_4321);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b2b_done_seen", done, 1);
    launch(2'b00, 32'hDEAD_BEEF, 32'h0000_1001);
    wait_idle();

    // Reset in the middle of a divide aborts it silently.
    do_op(2'b10, 32'hFFFF_0000, 32'd3);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_op(2'b10, 32'd100, 32'd7); wait_idle();

    do_op(2'b00, 32'd7, 32'd1);   wait_idle();
    do_op(2'b01, 32'd7, -32'sd1); wait_idle();
    do_op(2'b00, 32'd9, 32'd0);   wait_idle();

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = '0;
      if ($urandom_range(0, 5) == 0) rb = rb >> $urandom_range(1, 31);
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      do_op(ro, ra, rb);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("end_queue_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
